core_top_unit: RTL and testbench
================================

Name: core_top_unit

Overview:
- One compute core of the tiled transformer accelerator.
- Holds a weight memory (WMEM) and a KV cache, reachable from the global bus.
- Packs weight/KV words and activation words into two local FIFOs: LBUF for weights/KV, ABUF for activations.
- Runs a MAC_NUM-lane int8 dot product, accumulates, quantizes to int8, and forwards data to neighbour cores over vertical and horizontal links.

Parameters:
GBUS_DATA 64 global bus / link / memory word width
GBUS_ADDR 12 core memory address width
WMEM_DEPTH 1024 weight memory words
CACHE_DEPTH 1024 KV cache words
LBUF_DATA 512 local buffer entry width (LBUF_DATA/GBUS_DATA = 8 words per entry)
LBUF_DEPTH 16 entries per local buffer
MAC_NUM 64 MAC lanes (LBUF_DATA/IDATA_BIT)
IDATA_BIT 8 signed input/quantized element width
ODATA_BIT 32 accumulator and config width
CDATA_BIT 8 accumulation-count width
LBUF_ADDR clog2(LBUF_DEPTH) buffer pointer width

Ports:
clk in 1 clock
rst in 1 synchronous active-high reset
cfg_acc_num in CDATA_BIT dot products per output
cfg_quant_scale in ODATA_BIT signed multiplier
cfg_quant_bias in ODATA_BIT signed addend
cfg_quant_shift in ODATA_BIT arithmetic right shift (low 5 bits used)
gbus_addr in GBUS_ADDR global bus address
gbus_wen in 1 global write
gbus_wdata in GBUS_DATA global write data
gbus_ren in 1 global read
gbus_rdata out GBUS_DATA read data
gbus_rvalid out 1 read data valid
vlink_enable in 1 forward cmem read data downward
vlink_wdata in GBUS_DATA weight/KV word from upper core
vlink_wen in 1 vlink_wdata valid
vlink_rdata out GBUS_DATA forwarded word
vlink_rvalid out 1 forwarded word valid
hlink_wdata in GBUS_DATA activation word from left core
hlink_wen in 1 hlink_wdata valid
hlink_rdata out GBUS_DATA forwarded activation
hlink_rvalid out 1 forwarded activation valid
cmem_waddr in GBUS_ADDR result write address
cmem_wen in 1 write result packer to memory
cmem_raddr in GBUS_ADDR MAC-side read address
cmem_ren in 1 MAC-side read
lbuf_waddr out LBUF_ADDR LBUF write pointer
lbuf_raddr out LBUF_ADDR LBUF read pointer
lbuf_ren in 1 request pop for MAC
abuf_waddr out LBUF_ADDR ABUF write pointer
abuf_raddr out LBUF_ADDR ABUF read pointer
abuf_ren in 1 request pop for MAC
lbuf_empty out 1 / lbuf_full out 1 / abuf_empty out 1 / abuf_full out 1 FIFO status

Behaviour:
- Address map for gbus and cmem, decoded on addr[11:10]:
  - 00: WMEM, index addr[9:0].
  - 01: KV cache, index addr[9:0].
  - 10: unmapped.
  - 11: result packer; read-only, and only via gbus.
- Reads of unmapped regions return 0. Writes to unmapped regions and to 11 are ignored.
- gbus_wen writes the memory on the clock edge. gbus_wen and cmem_wen in the same cycle: gbus wins and the cmem write is dropped.
- gbus_ren: gbus_rdata and gbus_rvalid are registered, one cycle latency. Read-during-write to the same address returns old data.
- cmem_ren: the word at cmem_raddr is registered the next cycle (internal valid).
  - With vlink_enable=1, that word also drives vlink_rdata, with vlink_rvalid=1 in the same cycle.
  - vlink_rvalid=0 otherwise.
- LBUF packer source: vlink_wdata when vlink_wen=1, else the registered cmem read word when valid.
  - Both present in one cycle: vlink wins and the cmem word is not packed; it is still forwarded on vlink.
- hlink_wen:
  - Feeds hlink_wdata into the ABUF packer.
  - Echoes hlink_wdata on hlink_rdata with hlink_rvalid=1 the next cycle.
- Packers:
  - Each collects 8 GBUS words, word 0 in the LSBs.
  - On the 8th word, pushes one LBUF_DATA entry.
  - Push when full: entry dropped, pointers unchanged, packer restarts.
- FIFOs:
  - Circular, with waddr/raddr wrapping mod LBUF_DEPTH.
  - Extra wrap bit distinguishes full from empty.
  - Status flags are combinational from the pointers.
- MAC fire = lbuf_ren & abuf_ren & !lbuf_empty & !abuf_empty.
  - Fire pops both FIFOs in that cycle.
  - A fire request with either FIFO empty pops nothing.
- Dot product:
  - Sum over 64 lanes of signed int8 × signed int8, at ODATA_BIT width.
  - Registered one cycle after the pop.
- Accumulator:
  - Adds each dot product and counts them.
  - When count reaches cfg_acc_num (0 treated as 1), q = (acc*scale + bias) >>> shift, computed in 64 bits and saturated to [-128,127].
  - acc and count then clear.
- Result packer: q is shifted into byte slot k, with k incrementing and wrapping 0..7.
- cmem_wen writes the 64-bit packer to cmem_waddr.
- Reset, synchronous, clears:
  - all outputs
  - pointers, so empty=1 and full=0
  - packers, accumulator, count, result packer
- Reset does not clear memory contents. Reset mid-operation discards in-flight packing and MAC results.

Test Plan:
- Reset, then gbus write 1000 @addr 0, gbus_ren @0 → one cycle later gbus_rdata=1000 and gbus_rvalid=1; read @0x800 → 0.
- Write 8 words to WMEM 0..7, cmem_ren 0..7 with vlink_enable=1 → vlink_rdata echoes each word one cycle later; after 8 words lbuf_empty=0 and lbuf_waddr=1.
- 8 hlink writes of 1200 → hlink_rdata=1200 each next cycle; abuf_waddr=1.
- Fill both buffers with all lanes=1, cfg_acc_num=1, scale=16, bias=10, shift=2, fire → q=(64*16+10)>>2=258, saturated to 127; cmem_wen @0x400 then gbus read 0x400 → byte0=0x7F.
- Push 17 entries without popping → full=1 after 16, the 17th is dropped; lbuf_ren/abuf_ren on an empty buffer → pointers unchanged.
- gbus_wen and cmem_wen to the same address in one cycle → gbus data stored; cmem_waddr=0xFFF → no write.

Source files
------------

// File: rtl/core_top_unit.sv
// core_top_unit: one compute core of the tiled transformer accelerator.
// Weight memory plus KV cache on the global bus, two packing FIFOs (LBUF for
// weights/KV, ABUF for activations), a 64-lane int8 dot product, an
// accumulate/quantize stage and a byte-slot result packer.
module core_top_unit #(
    parameter int GBUS_DATA   = 64,
    parameter int GBUS_ADDR   = 12,
    parameter int WMEM_DEPTH  = 1024,
    parameter int CACHE_DEPTH = 1024,
    parameter int LBUF_DATA   = 512,
    parameter int LBUF_DEPTH  = 16,
    parameter int MAC_NUM     = 64,
    parameter int IDATA_BIT   = 8,
    parameter int ODATA_BIT   = 32,
    parameter int CDATA_BIT   = 8,
    localparam int LBUF_ADDR  = $clog2(LBUF_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CDATA_BIT-1:0] cfg_acc_num,
    input  logic [ODATA_BIT-1:0] cfg_quant_scale,
    input  logic [ODATA_BIT-1:0] cfg_quant_bias,
    input  logic [ODATA_BIT-1:0] cfg_quant_shift,
    input  logic [GBUS_ADDR-1:0] gbus_addr,
    input  logic                 gbus_wen,
    input  logic [GBUS_DATA-1:0] gbus_wdata,
    input  logic                 gbus_ren,
    output logic [GBUS_DATA-1:0] gbus_rdata,
    output logic                 gbus_rvalid,
    input  logic                 vlink_enable,
    input  logic [GBUS_DATA-1:0] vlink_wdata,
    input  logic                 vlink_wen,
    output logic [GBUS_DATA-1:0] vlink_rdata,
    output logic                 vlink_rvalid,
    input  logic [GBUS_DATA-1:0] hlink_wdata,
    input  logic                 hlink_wen,
    output logic [GBUS_DATA-1:0] hlink_rdata,
    output logic                 hlink_rvalid,
    input  logic [GBUS_ADDR-1:0] cmem_waddr,
    input  logic                 cmem_wen,
    input  logic [GBUS_ADDR-1:0] cmem_raddr,
    input  logic                 cmem_ren,
    output logic [LBUF_ADDR-1:0] lbuf_waddr,
    output logic [LBUF_ADDR-1:0] lbuf_raddr,
    input  logic                 lbuf_ren,
    output logic [LBUF_ADDR-1:0] abuf_waddr,
    output logic [LBUF_ADDR-1:0] abuf_raddr,
    input  logic                 abuf_ren,
    output logic                 lbuf_empty,
    output logic                 lbuf_full,
    output logic                 abuf_empty,
    output logic                 abuf_full
);
    localparam int WPE   = LBUF_DATA / GBUS_DATA;  // bus words per buffer entry
    localparam int PK_W  = $clog2(WPE);
    localparam int WIDX  = $clog2(WMEM_DEPTH);
    localparam int CIDX  = $clog2(CACHE_DEPTH);
    localparam logic [PK_W-1:0] PK_LAST = PK_W'(WPE - 1);

    typedef enum logic [1:0] {RG_WMEM = 2'b00, RG_KV = 2'b01, RG_NONE = 2'b10, RG_RES = 2'b11} region_e;

    logic [GBUS_DATA-1:0] wmem [WMEM_DEPTH];
    logic [GBUS_DATA-1:0] kv   [CACHE_DEPTH];
    logic [LBUF_DATA-1:0] lbuf_mem [LBUF_DEPTH];
    logic [LBUF_DATA-1:0] abuf_mem [LBUF_DEPTH];

    logic [GBUS_DATA-1:0] gbus_rdata_q, cmem_rdata_q, vlink_rdata_q, hlink_rdata_q, rp_q;
    logic                 gbus_rvalid_q, cmem_rvalid_q, vlink_rvalid_q, hlink_rvalid_q;
    logic [LBUF_DATA-1:0] lpk_data_q, apk_data_q;
    logic [PK_W-1:0]      lpk_cnt_q, apk_cnt_q, rp_k_q;
    logic [LBUF_ADDR:0]   lbuf_wptr_q, lbuf_rptr_q, abuf_wptr_q, abuf_rptr_q;
    logic signed [ODATA_BIT-1:0] dot_q, acc_q, acc_d, dot_sum, lane_a, lane_b;
    logic                 dot_vld_q;
    logic [CDATA_BIT-1:0] acc_cnt_q, acc_cnt_d, acc_num_eff;
    logic                 q_vld_d;
    logic [7:0]           q_byte_d;
    logic signed [63:0]   q_full;

    region_e              g_rg, w_rg, r_rg;
    logic [GBUS_DATA-1:0] gbus_word, cmem_word, lpk_word;
    logic                 lpk_vld, lpush, apush, fire;
    logic                 unused_shift;

    assign unused_shift = ^cfg_quant_shift[ODATA_BIT-1:5];
    assign g_rg = region_e'(gbus_addr[GBUS_ADDR-1 -: 2]);
    assign w_rg = region_e'(cmem_waddr[GBUS_ADDR-1 -: 2]);
    assign r_rg = region_e'(cmem_raddr[GBUS_ADDR-1 -: 2]);

    // Memory writes: gbus has priority, a same-cycle cmem write is dropped.
    // NOTE: memory arrays are deliberately not reset; only control state is.
    always_ff @(posedge clk) begin
        if (gbus_wen) begin
            if (g_rg == RG_WMEM)    wmem[gbus_addr[WIDX-1:0]] <= gbus_wdata;
            else if (g_rg == RG_KV) kv[gbus_addr[CIDX-1:0]]   <= gbus_wdata;
        end else if (cmem_wen) begin
            if (w_rg == RG_WMEM)    wmem[cmem_waddr[WIDX-1:0]] <= rp_q;
            else if (w_rg == RG_KV) kv[cmem_waddr[CIDX-1:0]]   <= rp_q;
        end
    end

    // Read address decode; the result packer is visible on gbus only.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gbus_word = '0;
        cmem_word = '0;
        case (g_rg)
            RG_WMEM: gbus_word = wmem[gbus_addr[WIDX-1:0]];
            RG_KV:   gbus_word = kv[gbus_addr[CIDX-1:0]];
            RG_RES:  gbus_word = rp_q;
            default: gbus_word = '0;
        endcase
        case (r_rg)
            RG_WMEM: cmem_word = wmem[cmem_raddr[WIDX-1:0]];
            RG_KV:   cmem_word = kv[cmem_raddr[CIDX-1:0]];
            default: cmem_word = '0;
        endcase
    end

    // Registered bus read port, MAC-side read, vertical and horizontal link outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            gbus_rdata_q   <= '0;
            gbus_rvalid_q  <= 1'b0;
            cmem_rdata_q   <= '0;
            cmem_rvalid_q  <= 1'b0;
            vlink_rdata_q  <= '0;
            vlink_rvalid_q <= 1'b0;
            hlink_rdata_q  <= '0;
            hlink_rvalid_q <= 1'b0;
        end else begin
            gbus_rvalid_q  <= gbus_ren;
            if (gbus_ren) gbus_rdata_q <= gbus_word;
            cmem_rvalid_q  <= cmem_ren;
            if (cmem_ren) cmem_rdata_q <= cmem_word;
            vlink_rvalid_q <= cmem_ren & vlink_enable;
            if (cmem_ren & vlink_enable) vlink_rdata_q <= cmem_word;
            hlink_rvalid_q <= hlink_wen;
            if (hlink_wen) hlink_rdata_q <= hlink_wdata;
        end
    end

    assign gbus_rdata   = gbus_rdata_q;
    assign gbus_rvalid  = gbus_rvalid_q;
    assign vlink_rdata  = vlink_rdata_q;
    assign vlink_rvalid = vlink_rvalid_q;
    assign hlink_rdata  = hlink_rdata_q;
    assign hlink_rvalid = hlink_rvalid_q;

    // Buffer status straight from the pointers; the extra MSB separates full from empty.
    assign lbuf_empty = (lbuf_wptr_q == lbuf_rptr_q);
    assign abuf_empty = (abuf_wptr_q == abuf_rptr_q);
    assign lbuf_full  = (lbuf_wptr_q == {~lbuf_rptr_q[LBUF_ADDR], lbuf_rptr_q[LBUF_ADDR-1:0]});
    assign abuf_full  = (abuf_wptr_q == {~abuf_rptr_q[LBUF_ADDR], abuf_rptr_q[LBUF_ADDR-1:0]});
    assign lbuf_waddr = lbuf_wptr_q[LBUF_ADDR-1:0];
    assign lbuf_raddr = lbuf_rptr_q[LBUF_ADDR-1:0];
    assign abuf_waddr = abuf_wptr_q[LBUF_ADDR-1:0];
    assign abuf_raddr = abuf_rptr_q[LBUF_ADDR-1:0];

    // A vlink word takes the slot; a coincident cmem word is only forwarded.
    assign lpk_vld  = vlink_wen | cmem_rvalid_q;
    assign lpk_word = vlink_wen ? vlink_wdata : cmem_rdata_q;
    assign lpush    = lpk_vld & (lpk_cnt_q == PK_LAST) & ~lbuf_full;
    assign apush    = hlink_wen & (apk_cnt_q == PK_LAST) & ~abuf_full;
    assign fire     = lbuf_ren & abuf_ren & ~lbuf_empty & ~abuf_empty;

    // Buffer entry storage; the 8th word goes straight into the top slot.
    always_ff @(posedge clk) begin
        if (lpush) lbuf_mem[lbuf_wptr_q[LBUF_ADDR-1:0]] <= {lpk_word, lpk_data_q[LBUF_DATA-GBUS_DATA-1:0]};
        if (apush) abuf_mem[abuf_wptr_q[LBUF_ADDR-1:0]] <= {hlink_wdata, apk_data_q[LBUF_DATA-GBUS_DATA-1:0]};
    end

    // Packers and FIFO pointers; a push into a full FIFO is dropped and the packer restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            lpk_data_q  <= '0;
            apk_data_q  <= '0;
            lpk_cnt_q   <= '0;
            apk_cnt_q   <= '0;
            lbuf_wptr_q <= '0;
            lbuf_rptr_q <= '0;
            abuf_wptr_q <= '0;
            abuf_rptr_q <= '0;
        end else begin
            if (lpk_vld) begin
                lpk_data_q[lpk_cnt_q*GBUS_DATA +: GBUS_DATA] <= lpk_word;
                lpk_cnt_q <= lpk_cnt_q + 1'b1;
            end
            if (hlink_wen) begin
                apk_data_q[apk_cnt_q*GBUS_DATA +: GBUS_DATA] <= hlink_wdata;
                apk_cnt_q <= apk_cnt_q + 1'b1;
            end
            if (lpush) lbuf_wptr_q <= lbuf_wptr_q + 1'b1;
            if (apush) abuf_wptr_q <= abuf_wptr_q + 1'b1;
            if (fire) begin
                lbuf_rptr_q <= lbuf_rptr_q + 1'b1;
                abuf_rptr_q <= abuf_rptr_q + 1'b1;
            end
        end
    end

    // Signed int8 x int8 dot product across all lanes of the head entries.
    always_comb begin
        dot_sum = '0;
        lane_a  = '0;
        lane_b  = '0;
        for (int i = 0; i < MAC_NUM; i++) begin
            lane_a  = {{(ODATA_BIT-IDATA_BIT){lbuf_mem[lbuf_rptr_q[LBUF_ADDR-1:0]][i*IDATA_BIT+IDATA_BIT-1]}},
                       lbuf_mem[lbuf_rptr_q[LBUF_ADDR-1:0]][i*IDATA_BIT +: IDATA_BIT]};
            lane_b  = {{(ODATA_BIT-IDATA_BIT){abuf_mem[abuf_rptr_q[LBUF_ADDR-1:0]][i*IDATA_BIT+IDATA_BIT-1]}},
                       abuf_mem[abuf_rptr_q[LBUF_ADDR-1:0]][i*IDATA_BIT +: IDATA_BIT]};
            dot_sum = dot_sum + lane_a * lane_b;
        end
    end

    // Accumulate, and on the last dot product quantize in 64 bits and saturate to int8.
    always_comb begin
        acc_num_eff = (cfg_acc_num == '0) ? CDATA_BIT'(1) : cfg_acc_num;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        q_vld_d     = 1'b0;
        q_byte_d    = '0;
        q_full      = '0;
        if (dot_vld_q) begin
            acc_d     = acc_q + dot_q;
            acc_cnt_d = acc_cnt_q + 1'b1;
            if (acc_cnt_d >= acc_num_eff) begin
                q_full = (64'(acc_d) * 64'(signed'(cfg_quant_scale)) + 64'(signed'(cfg_quant_bias)))
                         >>> cfg_quant_shift[4:0];
                if (q_full > 64'sd127)       q_byte_d = 8'h7F;
                else if (q_full < -64'sd128) q_byte_d = 8'h80;
                else                         q_byte_d = q_full[7:0];
                q_vld_d   = 1'b1;
                acc_d     = '0;
                acc_cnt_d = '0;
            end
        end
    end

    // MAC pipeline: dot product register, accumulator and byte-slot result packer.
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_q     <= '0;
            dot_vld_q <= 1'b0;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            rp_q      <= '0;
            rp_k_q    <= '0;
        end else begin
            dot_vld_q <= fire;
            if (fire) dot_q <= dot_sum;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            if (q_vld_d) begin
                rp_q[rp_k_q*8 +: 8] <= q_byte_d;
                rp_k_q <= rp_k_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_core_top_unit.sv
// tb_core_top_unit: directed-vector bench for core_top_unit with hand-computed expectations.
module tb_core_top_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_acc_num;
    logic [31:0] cfg_quant_scale, cfg_quant_bias, cfg_quant_shift;
    logic [11:0] gbus_addr, cmem_waddr, cmem_raddr;
    logic        gbus_wen, gbus_ren, gbus_rvalid;
    logic [63:0] gbus_wdata, gbus_rdata;
    logic        vlink_enable, vlink_wen, vlink_rvalid;
    logic [63:0] vlink_wdata, vlink_rdata;
    logic        hlink_wen, hlink_rvalid;
    logic [63:0] hlink_wdata, hlink_rdata;
    logic        cmem_wen, cmem_ren, lbuf_ren, abuf_ren;
    logic [3:0]  lbuf_waddr, lbuf_raddr, abuf_waddr, abuf_raddr;
    logic        lbuf_empty, lbuf_full, abuf_empty, abuf_full;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] rd;

    core_top_unit dut (
        .clk(clk), .rst(rst),
        .cfg_acc_num(cfg_acc_num), .cfg_quant_scale(cfg_quant_scale),
        .cfg_quant_bias(cfg_quant_bias), .cfg_quant_shift(cfg_quant_shift),
        .gbus_addr(gbus_addr), .gbus_wen(gbus_wen), .gbus_wdata(gbus_wdata),
        .gbus_ren(gbus_ren), .gbus_rdata(gbus_rdata), .gbus_rvalid(gbus_rvalid),
        .vlink_enable(vlink_enable), .vlink_wdata(vlink_wdata), .vlink_wen(vlink_wen),
        .vlink_rdata(vlink_rdata), .vlink_rvalid(vlink_rvalid),
        .hlink_wdata(hlink_wdata), .hlink_wen(hlink_wen),
        .hlink_rdata(hlink_rdata), .hlink_rvalid(hlink_rvalid),
        .cmem_waddr(cmem_waddr), .cmem_wen(cmem_wen),
        .cmem_raddr(cmem_raddr), .cmem_ren(cmem_ren),
        .lbuf_waddr(lbuf_waddr), .lbuf_raddr(lbuf_raddr), .lbuf_ren(lbuf_ren),
        .abuf_waddr(abuf_waddr), .abuf_raddr(abuf_raddr), .abuf_ren(abuf_ren),
        .lbuf_empty(lbuf_empty), .lbuf_full(lbuf_full),
        .abuf_empty(abuf_empty), .abuf_full(abuf_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic gbus_write(input logic [11:0] a, input logic [63:0] d);
        gbus_addr = a; gbus_wdata = d; gbus_wen = 1'b1;
        tick();
        gbus_wen = 1'b0;
    endtask

    task automatic gbus_read(input logic [11:0] a, output logic [63:0] d);
        gbus_addr = a; gbus_ren = 1'b1;
        tick();
        d = gbus_rdata;
        gbus_ren = 1'b0;
    endtask

    // Stream words into the packers: vw to LBUF over vlink, aw to ABUF over hlink.
    task automatic feed(input logic [63:0] vw, input logic ve, input logic [63:0] aw, input logic ae, input int n);
        vlink_wdata = vw; vlink_wen = ve;
        hlink_wdata = aw; hlink_wen = ae;
        tick(n);
        vlink_wen = 1'b0; hlink_wen = 1'b0;
    endtask

    task automatic fire(input int n);
        lbuf_ren = 1'b1; abuf_ren = 1'b1;
        tick(n);
        lbuf_ren = 1'b0; abuf_ren = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_acc_num = 8'd1; cfg_quant_scale = 32'd1; cfg_quant_bias = 32'd0; cfg_quant_shift = 32'd0;
        gbus_addr = '0; gbus_wen = 1'b0; gbus_wdata = '0; gbus_ren = 1'b0;
        vlink_enable = 1'b0; vlink_wdata = '0; vlink_wen = 1'b0; hlink_wdata = '0; hlink_wen = 1'b0;
        cmem_waddr = '0; cmem_wen = 1'b0; cmem_raddr = '0; cmem_ren = 1'b0; lbuf_ren = 1'b0; abuf_ren = 1'b0;
        do_reset();

        // Reset state
        check("rst_gbus_rvalid", gbus_rvalid, 1'b0);
        check("rst_vlink_rvalid", vlink_rvalid, 1'b0);
        check("rst_hlink_rvalid", hlink_rvalid, 1'b0);
        check("rst_empty", {lbuf_empty, abuf_empty, lbuf_full, abuf_full}, 4'b1100);
        check("rst_ptrs", {lbuf_waddr, lbuf_raddr, abuf_waddr, abuf_raddr}, 16'h0000);

        // Global bus write/read, unmapped read, read-during-write
        gbus_write(12'h000, 64'd1000);
        gbus_read(12'h000, rd);
        check("gbus_rd0", rd, 64'd1000);
        check("gbus_rvalid", gbus_rvalid, 1'b1);
        gbus_write(12'h800, 64'hDEAD);
        gbus_read(12'h800, rd);
        check("gbus_unmapped", rd, 64'd0);
        gbus_addr = 12'h000; gbus_wdata = 64'd2000; gbus_wen = 1'b1; gbus_ren = 1'b1;
        tick();
        gbus_wen = 1'b0; gbus_ren = 1'b0;
        check("gbus_rdw_old", gbus_rdata, 64'd1000);
        tick();
        check("gbus_rvalid_drop", gbus_rvalid, 1'b0);
        gbus_read(12'h000, rd);
        check("gbus_rdw_new", rd, 64'd2000);

        // cmem reads forwarded on vlink, packed into LBUF
        for (int i = 0; i < 8; i++) gbus_write(12'(i), 64'h1111_0000_0000_0000 | 64'(i));
        vlink_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmem_raddr = 12'(i); cmem_ren = 1'b1;
            tick();
            check("vlink_echo", vlink_rdata, 64'h1111_0000_0000_0000 | 64'(i));
            check("vlink_rvalid", vlink_rvalid, 1'b1);
        end
        cmem_ren = 1'b0;
        tick();
        vlink_enable = 1'b0;
        check("vlink_rvalid_off", vlink_rvalid, 1'b0);
        check("lbuf_empty_after8", lbuf_empty, 1'b0);
        check("lbuf_waddr_after8", 64'(lbuf_waddr), 64'd1);

        // hlink echo and ABUF packing
        for (int i = 0; i < 8; i++) begin
            hlink_wdata = 64'd1200; hlink_wen = 1'b1;
            tick();
            check("hlink_echo", hlink_rdata, 64'd1200);
        end
        hlink_wen = 1'b0;
        check("abuf_waddr_after8", 64'(abuf_waddr), 64'd1);
        tick();
        check("hlink_rvalid_off", hlink_rvalid, 1'b0);

        // MAC: all lanes 1, 64*16+10 = 1034 >>> 2 = 258 -> saturates to 0x7F
        do_reset();
        feed(64'h0101_0101_0101_0101, 1'b1, 64'h0101_0101_0101_0101, 1'b1, 8);
        cfg_acc_num = 8'd1; cfg_quant_scale = 32'd16; cfg_quant_bias = 32'd10; cfg_quant_shift = 32'd2;
        fire(1);
        check("fire_raddr", {lbuf_raddr, abuf_raddr}, 8'h11);
        check("fire_empty", {lbuf_empty, abuf_empty}, 2'b11);
        tick(3);
        cmem_waddr = 12'h400; cmem_wen = 1'b1;
        tick();
        cmem_wen = 1'b0;
        gbus_read(12'h400, rd);
        check("q_sat_kv", rd, 64'h0000_0000_0000_007F);

        // acc_num=2: lanes 2*(-1) -> dot -128 each, acc -256; (-768+100) >>> 3 = -84 = 0xAC
        feed(64'h0202_0202_0202_0202, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16);
        cfg_acc_num = 8'd2; cfg_quant_scale = 32'd3; cfg_quant_bias = 32'd100; cfg_quant_shift = 32'd3;
        fire(1);
        tick(3);
        gbus_read(12'hC00, rd);
        check("acc_partial", rd, 64'h0000_0000_0000_007F);
        fire(1);
        tick(3);
        gbus_read(12'hC00, rd);
        check("q_neg_slot1", rd, 64'h0000_0000_0000_AC7F);

        // acc_num=0 behaves as 1: dot 64, scale 1 -> 0x40 in slot 2
        feed(64'h0101_0101_0101_0101, 1'b1, 64'h0101_0101_0101_0101, 1'b1, 8);
        cfg_acc_num = 8'd0; cfg_quant_scale = 32'd1; cfg_quant_bias = 32'd0; cfg_quant_shift = 32'd0;
        fire(1);
        tick(3);
        gbus_read(12'hC00, rd);
        check("q_accnum0", rd, 64'h0000_0000_0040_AC7F);

        // gbus beats cmem; cmem writes land; region 11 is not writable
        gbus_addr = 12'h010; gbus_wdata = 64'h5555; gbus_wen = 1'b1;
        cmem_waddr = 12'h010; cmem_wen = 1'b1;
        tick();
        gbus_wen = 1'b0; cmem_wen = 1'b0;
        gbus_read(12'h010, rd);
        check("gbus_over_cmem", rd, 64'h5555);
        cmem_waddr = 12'h011; cmem_wen = 1'b1;
        tick();
        cmem_wen = 1'b0;
        gbus_read(12'h011, rd);
        check("cmem_write", rd, 64'h0000_0000_0040_AC7F);
        gbus_write(12'h3FF, 64'h77);
        cmem_waddr = 12'hFFF; cmem_wen = 1'b1;
        tick();
        cmem_wen = 1'b0;
        gbus_read(12'h3FF, rd);
        check("cmem_fff_no_wmem", rd, 64'h77);
        gbus_read(12'hC00, rd);
        check("cmem_fff_no_rp", rd, 64'h0000_0000_0040_AC7F);

        // Fill both FIFOs: full after 16 entries, 17th dropped
        do_reset();
        feed(64'h1, 1'b1, 64'h2, 1'b1, 16 * 8);
        check("full_after16", {lbuf_full, abuf_full, lbuf_empty, abuf_empty}, 4'b1100);
        check("waddr_wrap", {lbuf_waddr, abuf_waddr}, 8'h00);
        feed(64'h3, 1'b1, 64'h4, 1'b1, 8);
        check("drop17_waddr", {lbuf_waddr, abuf_waddr}, 8'h00);
        check("drop17_full", {lbuf_full, abuf_full}, 2'b11);
        fire(1);
        check("pop_from_full", {lbuf_raddr, abuf_raddr, 2'b00, lbuf_full, abuf_full}, 12'h110);

        // Pop requests with an empty FIFO do nothing
        do_reset();
        fire(1);
        check("pop_both_empty", {lbuf_raddr, abuf_raddr}, 8'h00);
        feed(64'h5, 1'b1, 64'h0, 1'b0, 8);
        fire(1);
        check("pop_abuf_empty", {lbuf_raddr, abuf_raddr, 3'b000, lbuf_empty}, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
